// File: rtl/gray_seq_gen.sv
// ---------------------------------------------------------------------------
// gray_seq_gen
//   N-bit reflected Gray code sequence generator with a valid/ready output
//   stream. Each run steps through a full 2^N-word cycle, counting up or down
//   from a loadable binary start index. Every word carries the Gray code, its
//   binary index, and the position of the bit that changed from the previous
//   word (the ruler sequence).
//
//   Handshake: a word is transferred on a posedge where out_valid && out_ready.
//   While out_valid=1 and out_ready=0 every output holds stable; out_valid
//   never drops without a transfer except on stop or reset.
//
// Parameters
//   N     code width, 1..16
//   WRAP  0 = one-shot (2^N words then IDLE), 1 = free-running until stop
//   FW    width of flip_pos (derived)
//
// Ports
//   clk        clock, posedge
//   rst_n      asynchronous active-low reset
//   start      begin a run (sampled only in IDLE)
//   stop       abort a run (synchronous, beats start and transfer)
//   dir        0 = up, 1 = down (latched with start)
//   load_val   binary start index (latched with start)
//   out_ready  consumer ready
//   out_valid  word valid
//   gray       Gray code of bin
//   bin        binary index of the current word
//   flip       flip_pos is meaningful (0 on the first word of a run)
//   flip_pos   index of the bit that differs from the previous word
//   last       final word of a 2^N-word cycle
//   busy       FSM is in RUN (also serves as the state debug view)
// ---------------------------------------------------------------------------
module gray_seq_gen #(
  parameter int N    = 3,
  parameter int WRAP = 0,
  parameter int FW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          dir,
  input  logic [N-1:0]  load_val,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [N-1:0]  gray,
  output logic [N-1:0]  bin,
  output logic          flip,
  output logic [FW-1:0] flip_pos,
  output logic          last,
  output logic          busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Word count reaches 2^N on the final word of a cycle.
  localparam logic [N:0] CNT_FULL = {1'b1, {N{1'b0}}};
  localparam logic [N:0] CNT_ONE  = (N+1)'(1);

  // Count of trailing zeros; an all-zero word (the wrap step) maps to N-1,
  // which is the bit that toggles between 0 and 2^N-1 in reflected Gray.
  function automatic logic [FW-1:0] ctz(input logic [N-1:0] v);
    logic [FW-1:0] r;
    r = FW'(N - 1);
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = FW'(i);
    end
    return r;
  endfunction

  function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  state_t        state_q, state_d;
  logic          dir_q, dir_d;
  logic [N:0]    cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [N-1:0]  gray_q, gray_d;
  logic [N-1:0]  bin_q, bin_d;
  logic          flip_q, flip_d;
  logic [FW-1:0] fpos_q, fpos_d;
  logic          last_q, last_d;

  // Candidate next word for a transfer in RUN.
  logic [N-1:0]  nxt_bin;
  logic [N:0]    nxt_cnt;

  always_comb begin
    nxt_bin = dir_q ? (bin_q - N'(1)) : (bin_q + N'(1));
    // After the final word of a cycle the count restarts (only reachable
    // in free-running mode; one-shot leaves RUN instead).
    nxt_cnt = last_q ? CNT_ONE : (cnt_q + CNT_ONE);
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    gray_d  = gray_q;
    bin_d   = bin_q;
    flip_d  = flip_q;
    fpos_d  = fpos_q;
    last_d  = last_q;

    unique case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        flip_d  = 1'b0;
        last_d  = 1'b0;
        if (start && !stop) begin
          state_d = ST_RUN;
          dir_d   = dir;
          cnt_d   = CNT_ONE;
          valid_d = 1'b1;
          bin_d   = load_val;
          gray_d  = to_gray(load_val);
          fpos_d  = '0;
          last_d  = (CNT_ONE == CNT_FULL);
        end
      end

      ST_RUN: begin
        if (stop) begin
          // Any pending word is dropped; bin/gray/flip_pos keep their values.
          state_d = ST_IDLE;
          valid_d = 1'b0;
          flip_d  = 1'b0;
          last_d  = 1'b0;
        end else if (valid_q && out_ready) begin
          if (last_q && (WRAP == 0)) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            flip_d  = 1'b0;
            last_d  = 1'b0;
          end else begin
            bin_d  = nxt_bin;
            gray_d = to_gray(nxt_bin);
            cnt_d  = nxt_cnt;
            flip_d = 1'b1;
            // Up: the carry stops at the lowest zero of the old word, which is
            // the lowest one of the new word. Down: mirror image.
            fpos_d = dir_q ? ctz(bin_q) : ctz(nxt_bin);
            last_d = (nxt_cnt == CNT_FULL);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      gray_q  <= '0;
      bin_q   <= '0;
      flip_q  <= 1'b0;
      fpos_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      gray_q  <= gray_d;
      bin_q   <= bin_d;
      flip_q  <= flip_d;
      fpos_q  <= fpos_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign gray      = gray_q;
  assign bin       = bin_q;
  assign flip      = flip_q;
  assign flip_pos  = fpos_q;
  assign last      = last_q;
  assign busy      = (state_q == ST_RUN);

endmodule

// File: tb/tb_gray_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_gray_seq_gen
//   Two N=3 instances: u_w0 (one-shot) and u_w1 (free-running). They share
//   every input except start. Inputs change 1 time unit after a posedge and
//   outputs are sampled at the same point, i.e. they show the effect of the
//   edge just taken.
// ---------------------------------------------------------------------------
module tb_gray_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, start1, stop, dir, out_ready;
  logic [2:0] load_val;

  logic       w0_valid, w0_flip, w0_last, w0_busy;
  logic [2:0] w0_gray, w0_bin;
  logic [1:0] w0_fpos;
  logic       w1_valid, w1_flip, w1_last, w1_busy;
  logic [2:0] w1_gray, w1_bin;
  logic [1:0] w1_fpos;

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  gray_seq_gen #(.N(3), .WRAP(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stop(stop), .dir(dir),
    .load_val(load_val), .out_ready(out_ready), .out_valid(w0_valid),
    .gray(w0_gray), .bin(w0_bin), .flip(w0_flip), .flip_pos(w0_fpos),
    .last(w0_last), .busy(w0_busy)
  );

  gray_seq_gen #(.N(3), .WRAP(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop), .dir(dir),
    .load_val(load_val), .out_ready(out_ready), .out_valid(w1_valid),
    .gray(w1_gray), .bin(w1_bin), .flip(w1_flip), .flip_pos(w1_fpos),
    .last(w1_last), .busy(w1_busy)
  );

  typedef struct {
    logic       st, sp, dr;
    logic [2:0] ld;
    logic       rdy;
    logic       v;
    logic [2:0] g, b;
    logic       f;
    logic [1:0] fp;
    logic       l, bz;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(int st, int sp, int dr, int ld, int rdy,
                              int v, int g, int b, int f, int fp, int l, int bz);
    vec_t r;
    r.st = st[0]; r.sp = sp[0]; r.dr = dr[0]; r.ld = 3'(ld); r.rdy = rdy[0];
    r.v = v[0]; r.g = 3'(g); r.b = 3'(b); r.f = f[0]; r.fp = 2'(fp);
    r.l = l[0]; r.bz = bz[0];
    return r;
  endfunction

  // driver
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_w0(input string tag, input logic v, input logic [2:0] g,
                        input logic [2:0] b, input logic f, input logic [1:0] fp,
                        input logic l, input logic bz);
    chk({tag, ".valid"}, 32'(w0_valid), 32'(v));
    chk({tag, ".gray"},  32'(w0_gray),  32'(g));
    chk({tag, ".bin"},   32'(w0_bin),   32'(b));
    chk({tag, ".flip"},  32'(w0_flip),  32'(f));
    chk({tag, ".fpos"},  32'(w0_fpos),  32'(fp));
    chk({tag, ".last"},  32'(w0_last),  32'(l));
    chk({tag, ".busy"},  32'(w0_busy),  32'(bz));
  endtask

  // Reflected Gray code and ruler position indexed by binary value, up count.
  logic [2:0] gtab[8]  = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
  logic [1:0] fptab[8] = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; stop = 1'b0; dir = 1'b0;
    out_ready = 1'b0; load_val = 3'd0;

    //          st sp dr ld rdy | v  g  b  f fp  l bz
    // one-shot up from 0, backpressure on gray 010, start ignored in RUN
    tbl[0]  = mk(1, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 1);
    tbl[1]  = mk(0, 0, 0, 0, 1,  1, 1, 1, 1, 0, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0, 1,  1, 3, 2, 1, 1, 0, 1);
    tbl[3]  = mk(0, 0, 0, 0, 1,  1, 2, 3, 1, 0, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0,  1, 2, 3, 1, 0, 0, 1);
    tbl[5]  = mk(1, 0, 1, 6, 0,  1, 2, 3, 1, 0, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0,  1, 2, 3, 1, 0, 0, 1);
    tbl[7]  = mk(0, 0, 0, 0, 1,  1, 6, 4, 1, 2, 0, 1);
    tbl[8]  = mk(0, 0, 0, 0, 1,  1, 7, 5, 1, 0, 0, 1);
    tbl[9]  = mk(0, 0, 0, 0, 1,  1, 5, 6, 1, 1, 0, 1);
    tbl[10] = mk(0, 0, 0, 0, 1,  1, 4, 7, 1, 0, 1, 1);
    tbl[11] = mk(0, 0, 0, 0, 1,  0, 4, 7, 0, 0, 0, 0);
    // start and stop together in IDLE: no launch
    tbl[12] = mk(1, 1, 0, 5, 1,  0, 4, 7, 0, 0, 0, 0);
    // one-shot down from 5; dir changes after launch must not matter
    tbl[13] = mk(1, 0, 1, 5, 1,  1, 7, 5, 0, 0, 0, 1);
    tbl[14] = mk(0, 0, 0, 0, 1,  1, 6, 4, 1, 0, 0, 1);
    tbl[15] = mk(0, 0, 0, 0, 1,  1, 2, 3, 1, 2, 0, 1);
    tbl[16] = mk(0, 0, 0, 0, 1,  1, 3, 2, 1, 0, 0, 1);
    tbl[17] = mk(0, 0, 0, 0, 1,  1, 1, 1, 1, 1, 0, 1);
    tbl[18] = mk(0, 0, 0, 0, 1,  1, 0, 0, 1, 0, 0, 1);
    tbl[19] = mk(0, 0, 0, 0, 1,  1, 4, 7, 1, 2, 0, 1);
    tbl[20] = mk(0, 0, 0, 0, 1,  1, 5, 6, 1, 0, 1, 1);
    tbl[21] = mk(0, 0, 0, 0, 1,  0, 5, 6, 0, 0, 0, 0);
    // stop beats a simultaneous transfer; pending word dropped, values held
    tbl[22] = mk(1, 0, 0, 2, 0,  1, 3, 2, 0, 0, 0, 1);
    tbl[23] = mk(0, 1, 0, 0, 1,  0, 3, 2, 0, 0, 0, 0);
    tbl[24] = mk(0, 0, 0, 0, 1,  0, 3, 2, 0, 0, 0, 0);

    // reset state, with no clock edge seen yet
    #2;
    chk_w0("reset_w0", 1'b0, 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("reset_w1.valid", 32'(w1_valid), 32'd0);
    chk("reset_w1.bin",   32'(w1_bin),   32'd0);
    #10 rst_n = 1'b1;
    step();

    for (int i = 0; i < 25; i++) begin
      start0 = tbl[i].st; stop = tbl[i].sp; dir = tbl[i].dr;
      load_val = tbl[i].ld; out_ready = tbl[i].rdy;
      step();
      chk_w0($sformatf("vec%0d", i), tbl[i].v, tbl[i].g, tbl[i].b, tbl[i].f,
             tbl[i].fp, tbl[i].l, tbl[i].bz);
    end
    start0 = 1'b0; stop = 1'b0; dir = 1'b0; out_ready = 1'b1;

    // asynchronous reset mid-run at word 4
    load_val = 3'd0; start0 = 1'b1; step(); start0 = 1'b0;
    step(); step(); step();
    chk("rst_pre.bin", 32'(w0_bin), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk_w0("rst_async", 1'b0, 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_w0("rst_idle", 1'b0, 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    load_val = 3'd3; start0 = 1'b1; step(); start0 = 1'b0;
    chk_w0("rst_restart", 1'b1, 3'd2, 3'd3, 1'b0, 2'd0, 1'b0, 1'b1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("rst_stop.valid", 32'(w0_valid), 32'd0);

    // free-running: 17 words across two wraps, then stop
    load_val = 3'd0; dir = 1'b0; out_ready = 1'b1;
    start1 = 1'b1; step(); start1 = 1'b0;
    for (int w = 1; w <= 17; w++) begin
      int b;
      b = (w - 1) % 8;
      chk($sformatf("wrap_w%0d.valid", w), 32'(w1_valid), 32'd1);
      chk($sformatf("wrap_w%0d.bin", w),   32'(w1_bin),   32'(b));
      chk($sformatf("wrap_w%0d.gray", w),  32'(w1_gray),  32'(gtab[b]));
      chk($sformatf("wrap_w%0d.flip", w),  32'(w1_flip),  (w == 1) ? 32'd0 : 32'd1);
      chk($sformatf("wrap_w%0d.fpos", w),  32'(w1_fpos),  (w == 1) ? 32'd0 : 32'(fptab[b]));
      chk($sformatf("wrap_w%0d.last", w),  32'(w1_last),  (w == 8 || w == 16) ? 32'd1 : 32'd0);
      if (w < 17) step();
    end
    stop = 1'b1; step(); stop = 1'b0;
    chk("wrap_stop.valid", 32'(w1_valid), 32'd0);
    chk("wrap_stop.busy",  32'(w1_busy),  32'd0);

    // free-running again: stop during word 11 while out_ready is low
    start1 = 1'b1; step(); start1 = 1'b0;
    for (int w = 1; w < 11; w++) step();
    chk("w11.bin",  32'(w1_bin),  32'd2);
    chk("w11.flip", 32'(w1_flip), 32'd1);
    chk("w11.fpos", 32'(w1_fpos), 32'd1);
    out_ready = 1'b0; stop = 1'b1; step(); stop = 1'b0;
    chk("w11_stop.valid", 32'(w1_valid), 32'd0);
    chk("w11_stop.busy",  32'(w1_busy),  32'd0);
    chk("w11_stop.bin",   32'(w1_bin),   32'd2);
    step();
    chk("w11_idle.valid", 32'(w1_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gray_seq_gen.md
Name: gray_seq_gen

Overview:
Parametrised N-bit reflected Gray code sequence generator with a valid/ready output stream. Each run steps through a full 2^N-word cycle, up or down, from a loadable start index. Every word carries the Gray code, its binary index, and the position of the bit that changed from the previous word (the ruler sequence). One-shot and free-running wrap modes are supported. It replaces the fixed, table-based generator with a counter-based datapath that is synthesizable at any N.

Parameters:
N, 3, code width in bits; legal range 1..16
WRAP, 0, 0 = one-shot (stop after 2^N words); 1 = free-running until stop
FW, (N>1)?$clog2(N):1, width of flip_pos; derived, do not override

Ports:
clk  in  1  clock; all logic on the posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a run; sampled only in IDLE
stop  in  1  abort a run; synchronous
dir  in  1  0 = count up, 1 = count down; sampled with start
load_val  in  N  binary start index; sampled with start
out_ready  in  1  consumer ready
out_valid  out  1  word valid
gray  out  N  Gray code = bin ^ (bin >> 1)
bin  out  N  binary index of the current word
flip  out  1  1 when flip_pos is meaningful; 0 on the first word of a run
flip_pos  out  FW  index of the bit that differs from the previous word
last  out  1  final word of a 2^N-word cycle
busy  out  1  state is RUN

Behaviour:
- Reset (async assert, deassert synchronised externally): state IDLE; all outputs 0.
- States: IDLE, RUN.
  - IDLE -> RUN on start && !stop.
  - RUN -> IDLE on stop, or on a transfer with last=1 when WRAP=0.
  - start in RUN is ignored.
- Launch: start at posedge k -> from posedge k the outputs show out_valid=1, bin=load_val, gray=G(load_val), flip=0, flip_pos=0. The internal word count cnt (N+1 bits) clears to 1. dir is latched for the whole run.
- Transfer: out_valid && out_ready at a posedge.
  - Next word: bin+1 (up) or bin-1 (down), modulo 2^N; cnt+1.
  - While out_ready=0, every output holds stable; no word is skipped or duplicated.
- flip_pos: ctz(new bin) when counting up; ctz(old bin) when counting down. The wrap cases (ctz(0)) give N-1.
  - flip=1 on every word after the first of the run, including the first word after a wrap cycle in WRAP=1.
- last: 1 when cnt == 2^N.
  - WRAP=1: after a transfer with last, cnt reloads to 1 and counting continues; last recurs every 2^N words.
  - WRAP=0: after the last transfer, out_valid=0 at the next edge.
- stop in RUN: out_valid=0 and state IDLE at the next edge; any unaccepted word is dropped. stop beats both start and a simultaneous transfer.
- In IDLE: out_valid=0; gray, bin and flip_pos hold their last values; flip=0; last=0.
- N=1: sequence is 0,1; flip_pos is always 0.
- No combinational path from the inputs to the outputs; all outputs are registered.

Test Plan:
1. N=3, WRAP=0, dir=0, load_val=0, out_ready=1 -> gray 000,001,011,010,110,111,101,100 on consecutive cycles; flip_pos x,0,1,0,2,0,1,0 (flip=0 on the first word); last only on 100; out_valid low the next cycle; busy low.
2. N=3, dir=1, load_val=5 -> bin 5,4,3,2,1,0,7,6; gray 111,110,010,011,001,000,100,101; flip_pos x,0,2,0,1,0,2,0; last on bin 6.
3. Backpressure in scenario 1: out_ready low for 3 cycles while gray=010 -> gray/flip_pos held at 010/0; next accepted word is 110; still exactly 8 transfers.
4. WRAP=1, N=3, up from 0 -> the 9th word is gray 000, flip=1, flip_pos=2; last on words 8 and 16. Assert stop during word 11 with out_ready=0 -> out_valid=0 and busy=0 next cycle.
5. rst_n low mid-run (word 4) -> all outputs 0 immediately, with no clock edge needed. After release, no output until start; start with load_val=3 -> first word bin=3, gray=010, flip=0.
6. start pulsed during RUN -> ignored; sequence unchanged. start and stop together in IDLE -> stays IDLE, out_valid=0.
